miriscv_mem_arbiter: RTL

- Shares the single-port synchronous on-chip RAM of miriscv_top between the core's instruction-fetch port and its load/store (LSU) port.
- Sits between the core and the RAM instance inside miriscv_top.
- Grants at most one request per cycle and routes the 1-cycle-latency read data back to the owner.
- Flags out-of-range addresses.

---
 rtl/miriscv_mem_pkg.sv | 27 ++
 rtl/miriscv_starve_cnt.sv | 43 ++++
 rtl/miriscv_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/miriscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_mem_pkg
// Shared definitions for the miriscv on-chip RAM arbiter.
//   WORD_BYTES / WORD_SHIFT : bytes per RAM word and byte->word shift
//   owner_e                 : registered response-owner state encoding
//   addr_in_range()         : true when a byte address maps into the RAM
// ---------------------------------------------------------------------------
package miriscv_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESP_I     = 3'd1,
    RESP_D     = 3'd2,
    RESP_I_ERR = 3'd3,
    RESP_D_ERR = 3'd4
  } owner_e;

  // Low address bits are dropped: misaligned accesses are plain word accesses.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned ram_size);
    return (addr >> WORD_SHIFT) < ram_size;
  endfunction

endpackage

// File: rtl/miriscv_starve_cnt.sv
// ---------------------------------------------------------------------------
// miriscv_starve_cnt
// Saturating count of consecutive cycles the instruction port was denied.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : count one more denied cycle (saturates at MAX_WAIT)
//   clr_i        : restart from zero (wins over inc_i)
//   at_max_o     : counter has reached MAX_WAIT
// ---------------------------------------------------------------------------
module miriscv_starve_cnt #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max_o = (cnt_q == CW'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_mem_arbiter
// Shares one single-port synchronous RAM between instruction fetch and LSU.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   instr_*             : fetch port  (req/addr in; gnt/rvalid/rdata/err out)
//   data_*              : LSU port    (req/we/be/addr/wdata in;
//                                      gnt/rvalid/rdata/err out)
//   mem_*               : RAM port    (req/we/be/word addr/wdata out; rdata in)
//
// Handshake: a request is accepted in the cycle its gnt is high (gnt is
// combinational from that cycle's req). Every accepted request gets exactly
// one rvalid in the following cycle; there is no back-pressure. A requester
// that is not granted must keep req asserted; no pending state is kept here.
// rdata/err are zero whenever the matching rvalid is low.
//
// Data has priority, except that an instruction request that has been
// denied MAX_WAIT cycles in a row is granted over data.
// ---------------------------------------------------------------------------
module miriscv_mem_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 512,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        data_req_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_addr_i,
  input  logic [31:0]                 data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_err_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [$clog2(RAM_SIZE)-1:0] mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int unsigned AW = $clog2(RAM_SIZE);

  owner_e owner_q, owner_d;
  logic   resp_store_q, resp_store_d;  // pending data response is a store
  logic   instr_in_range, data_in_range;
  logic   at_max;

  // ---------------- grant path (combinational) ----------------
  always_comb begin
    instr_in_range = addr_in_range(instr_addr_i, RAM_SIZE);
    data_in_range  = addr_in_range(data_addr_i, RAM_SIZE);
    instr_gnt_o    = !rst_i && instr_req_i && (at_max || !data_req_i);
    data_gnt_o     = !rst_i && data_req_i && !instr_gnt_o;
  end

  // Out-of-range requests are granted but never reach the RAM.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (instr_gnt_o && instr_in_range) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i[AW+WORD_SHIFT-1:WORD_SHIFT];
    end else if (data_gnt_o && data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i[AW+WORD_SHIFT-1:WORD_SHIFT];
      mem_wdata_o = data_wdata_i;
    end
  end

  miriscv_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (instr_req_i && !instr_gnt_o),
    .clr_i    (!instr_req_i || instr_gnt_o),
    .at_max_o (at_max)
  );

  // ---------------- owner FSM / response path ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= IDLE;
      resp_store_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      resp_store_q <= resp_store_d;
    end
  end

  always_comb begin
    owner_d        = IDLE;
    resp_store_d   = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;

    if (instr_gnt_o) begin
      owner_d = instr_in_range ? RESP_I : RESP_I_ERR;
    end else if (data_gnt_o) begin
      owner_d      = data_in_range ? RESP_D : RESP_D_ERR;
      resp_store_d = data_we_i;
    end

    // A response that falls in a reset cycle is dropped, not delivered late.
    if (!rst_i) begin
      case (owner_q)
        RESP_I: begin
          instr_rvalid_o = 1'b1;
          instr_rdata_o  = mem_rdata_i;
        end
        RESP_I_ERR: begin
          instr_rvalid_o = 1'b1;
          instr_err_o    = 1'b1;
        end
        RESP_D: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = resp_store_q ? 32'h0 : mem_rdata_i;
        end
        RESP_D_ERR: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
